// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one digit per clock, full 2*WIDTH-bit product on cHI/cLOW.
// Optional macro BOOTH_UNSIGNED_EN adds an is_signed port for unsigned x unsigned operation.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef BOOTH_UNSIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cHI,
    output logic [WIDTH-1:0] cLOW
);
    // Accumulator carries one guard bit beyond +/-2A so zero-extended unsigned operands cannot overflow.
    localparam int AW = WIDTH + 3;
    localparam int ML = WIDTH + 2;
    localparam int CW = $clog2(WIDTH / 2 + 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state, state_nxt;
    logic signed [AW-1:0]   mcand, hi, pp, sum, hi_nxt;
    logic        [ML-1:0]   lo, lo_nxt;
    logic                   bm1;
    logic        [CW-1:0]   cnt, n_dig;
    logic                   accept, last, sgn, sgn_ld;
    logic        [2:0]      dig;
    logic [AW+ML-1:0]       full;
    logic [2*WIDTH-1:0]     prod;

`ifdef BOOTH_UNSIGNED_EN
    logic sgn_q;
    assign sgn    = sgn_q;
    assign sgn_ld = is_signed;
`else
    assign sgn    = 1'b1;
    assign sgn_ld = 1'b1;
`endif

    assign accept = start && (state == IDLE || state == DONE);
    assign n_dig  = sgn ? CW'(WIDTH / 2) : CW'(WIDTH / 2 + 1);
    assign last   = (cnt == n_dig);
    assign busy   = (state == BUSY);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Booth recoding of {b[2k+1], b[2k], b[2k-1]}
    assign dig = {lo[1:0], bm1};
    always_comb begin
        pp = '0;
        case (dig)
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand <<< 1;
            3'b100:         pp = -(mcand <<< 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
    end

    // Shift-right accumulation: retired low product bits enter lo from the top.
    assign sum    = hi + pp;
    assign hi_nxt = sum >>> 2;
    assign lo_nxt = {sum[1:0], lo[ML-1:2]};

    // Signed runs use WIDTH/2 shifts, leaving two unconsumed multiplier bits at the bottom of lo.
    assign full = {hi, lo};
    assign prod = sgn ? full[2 +: 2*WIDTH] : full[0 +: 2*WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            bm1   <= 1'b0;
            cnt   <= '0;
            cHI   <= '0;
            cLOW  <= '0;
`ifdef BOOTH_UNSIGNED_EN
            sgn_q <= 1'b1;
`endif
        end else if (accept) begin
            mcand <= {{3{sgn_ld & a[WIDTH-1]}}, a};
            hi    <= '0;
            lo    <= {{2{sgn_ld & b[WIDTH-1]}}, b};
            bm1   <= 1'b0;
            cnt   <= '0;
`ifdef BOOTH_UNSIGNED_EN
            sgn_q <= is_signed;
`endif
        end else if (state == BUSY) begin
            if (last) begin
                cHI  <= prod[2*WIDTH-1:WIDTH];
                cLOW <= prod[WIDTH-1:0];
            end else begin
                hi  <= hi_nxt;
                lo  <= lo_nxt;
                bm1 <= lo[1];
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed-vector bench for booth_mul_seq (WIDTH=32, signed build).
module tb_booth_mul_seq;
    localparam int W   = 32;
    localparam int LAT = 17;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done;
    logic [W-1:0] cHI, cLOW;
`ifdef BOOTH_UNSIGNED_EN
    logic         is_signed = 1'b1;
`endif

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef BOOTH_UNSIGNED_EN
        .is_signed(is_signed),
`endif
        .busy(busy), .done(done), .cHI(cHI), .cLOW(cLOW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b, hi, lo;
    } vec_t;

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Issues one op, scrambles operands after acceptance, returns at the negedge where done is seen.
    task automatic run_op(input logic [W-1:0] ia, ib, output int lat, output int nbusy, output bit clash);
        @(negedge clk); start = 1'b1; a = ia; b = ib;
        @(negedge clk); start = 1'b0; a = $urandom; b = $urandom;
        lat = -1; nbusy = 0; clash = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) nbusy++;
            if (busy && done) clash = 1'b1;
            if (done) begin lat = k; break; end
            @(negedge clk);
        end
    endtask

    vec_t vecs[11];
    int   lat, nbusy;
    bit   clash, held, seen;
    logic [W-1:0] ra, rb;
    logic signed [63:0] sa, sb, gp;

    initial begin
        vecs[0]  = '{32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[2]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[3]  = '{32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[5]  = '{32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
        vecs[6]  = '{32'h00000001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[7]  = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[8]  = '{32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFB};
        vecs[9]  = '{32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[10] = '{32'hFFFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000002};

        #12;
        chk("reset_outputs", {30'd0, busy, done, cHI}, 64'd0);
        chk("reset_clow", {32'd0, cLOW}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, lat, nbusy, clash);
            chk($sformatf("vec%0d_lat", i), lat, LAT);
            chk($sformatf("vec%0d_busy", i), {31'd0, clash} | nbusy, LAT);
            chk($sformatf("vec%0d_prod", i), {cHI, cLOW}, {vecs[i].hi, vecs[i].lo});
            @(negedge clk);
            chk($sformatf("vec%0d_pulse", i), {63'd0, done}, 64'd0);
        end

        // start pulsed mid-BUSY with other operands must be ignored
        @(negedge clk); start = 1'b1; a = 32'd7; b = 32'hFFFFFFFD;
        @(negedge clk); start = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            start = (k == 5); a = 32'd9; b = 32'd9;
            if (done) begin lat = k; break; end
            @(negedge clk);
        end
        start = 1'b0;
        chk("midbusy_lat", lat, LAT);
        chk("midbusy_prod", {cHI, cLOW}, 64'hFFFFFFFF_FFFFFFEB);

        // back-to-back: start held in DONE, old result held until the next done
        run_op(32'd5, 32'd5, lat, nbusy, clash);
        chk("b2b_first", {cHI, cLOW}, 64'd25);
        start = 1'b1; a = 32'd2; b = 32'd3;
        @(negedge clk); start = 1'b0;
        lat = -1; held = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin lat = k; break; end
            if (cLOW !== 32'd25) held = 1'b0;
            @(negedge clk);
        end
        chk("b2b_lat", lat, LAT);
        chk("b2b_held", {63'd0, held}, 64'd1);
        chk("b2b_prod", {cHI, cLOW}, 64'd6);

        // async reset mid-operation
        @(negedge clk); start = 1'b1; a = 32'd3; b = 32'd5;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0; #1;
        chk("rst_mid_ctrl", {62'd0, busy, done}, 64'd0);
        chk("rst_mid_prod", {cHI, cLOW}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin @(negedge clk); if (done) seen = 1'b1; end
        chk("rst_no_done", {63'd0, seen}, 64'd0);
        run_op(32'd3, 32'd4, lat, nbusy, clash);
        chk("rst_after_lat", lat, LAT);
        chk("rst_after_prod", {cHI, cLOW}, 64'd12);

        // random signed operands against a 64-bit golden product
        for (int i = 0; i < 200; i++) begin
            ra = $urandom; rb = $urandom;
            sa = $signed(ra); sb = $signed(rb); gp = sa * sb;
            run_op(ra, rb, lat, nbusy, clash);
            chk($sformatf("rnd%0d", i), {cHI, cLOW}, gp);
            if (lat != LAT || clash) chk($sformatf("rnd%0d_lat", i), lat, LAT);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
